prbs_gen_par: RTL and testbench
===============================

Name: prbs_gen_par

Overview:
- Parametrised, multi-polynomial PRBS pattern generator for the BERT transmit path.
- Successor to the fixed PRBS-13 LFSR. Runtime-selectable PRBS7/9/13/15/23/31, DATA_W bits per clock, seed load, valid/ready output handshake, single-bit error injection and a transferred-word counter.
- Feeds the serializer/TX datapath. The matching checker is seeded from the same mode/seed.

Parameters:
- DATA_W, 16, bits produced per clock (legal 1..64).
- CNT_W, 32, width of word_cnt.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  allow generation of new words.
- load  in  1  one-cycle pulse: load seed and mode.
- mode  in  3  polynomial select, sampled only at load or reset.
- seed  in  31  LFSR seed, low N bits used.
- inj_err  in  1  one-cycle pulse: corrupt one output word.
- dout  out  DATA_W  pattern word.
- valid  out  1  dout holds a word.
- ready  in  1  downstream accepts dout.
- word_cnt  out  CNT_W  count of accepted words.

Behaviour:
- Mode codes and polynomials (N = length):
  - 0: PRBS7, x^7+x^6+1
  - 1: PRBS9, x^9+x^5+1
  - 2: PRBS13, x^13+x^12+x^2+x+1
  - 3: PRBS15, x^15+x^14+1
  - 4: PRBS23, x^23+x^18+1
  - 5: PRBS31, x^31+x^28+1
  - 6 and 7: decode as PRBS7.
- LFSR step (Fibonacci): new bit b = XOR of state bits at tap exponents minus 1 (PRBS7: b = s[6]^s[5]). State shifts left one place, b enters s[0], bits at or above N are held at 0.
- Per-word ordering: each word is DATA_W consecutive steps. The first-generated b goes to dout[DATA_W-1] and the last to dout[0]. State advances DATA_W steps per produced word, computed combinationally in one cycle.
- Reset (sync, priority over everything):
  - mode_q <= mode; state <= all ones in the low N bits.
  - dout <= 0, valid <= 0, word_cnt <= 0, inject-pending <= 0.
- Load (priority over en and handshake):
  - mode_q <= mode; state <= seed[N-1:0], or all ones if that is zero.
  - valid <= 0, inject-pending <= 0. word_cnt is unchanged.
  - Any word held in dout is discarded.
- Produce condition: en && (!valid || ready), with no reset or load that cycle. Then dout <= next word, state advances, valid <= 1.
  - If (!valid || ready) && !en: valid <= 0 and dout is held.
- Stall: while valid && !ready, dout, state and valid are frozen (AXI-style). en going low during a stall does not drop valid.
- Latency: with en=1 and ready=1, valid rises on the first edge after reset/load deasserts. From then on, one new word every cycle.
- word_cnt increments on every valid && ready cycle and wraps modulo 2^CNT_W.
- Error injection:
  - inj_err sets inject-pending.
  - The next produced word (including one produced in the same cycle as inj_err) has dout[0] inverted, and inject-pending then clears.
  - The LFSR state is never corrupted, so the error is a single isolated bit.
  - Multiple inj_err pulses before a word is produced collapse to one error.
- mode changes outside load/reset have no effect.

Test Plan:
- PRBS7 default seed: reset with mode=0, DATA_W=8, en=1, ready=1 -> first dout=8'h02, valid high on the first edge after reset, a new word every cycle.
- Period check: mode=0, DATA_W=1 -> bit stream repeats with period exactly 127. mode=2 -> period exactly 8191. Over one full period, the set of states visited contains no zero.
- Zero seed: load with seed=0, mode=3 -> state is all ones (15 ones), the output matches the post-reset PRBS15 stream, and valid drops for one cycle.
- Backpressure: hold ready=0 for 5 cycles mid-stream -> dout and valid are stable. After release, the word sequence continues with no gap or skip, and word_cnt counts only accepted words.
- Error injection: a single inj_err pulse -> exactly one produced word differs from the reference model, and only in dout[0]. All subsequent words match the reference.
- Simultaneous events: reset asserted together with load and inj_err -> reset values result and no error is injected later. A load arriving during a stall discards the held word.

Source files
------------

// File: rtl/prbs_gen_par.sv
// prbs_gen_par: runtime-selectable PRBS7..31 generator, DATA_W bits/clock, valid/ready output, error injection
module prbs_gen_par #(
  parameter int DATA_W = 16,
  parameter int CNT_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [2:0]        mode,
  input  logic [30:0]       seed,
  input  logic              inj_err,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  input  logic              ready,
  output logic [CNT_W-1:0]  word_cnt
);
  function automatic logic [30:0] len_of(input logic [2:0] m);
    return m == 3'd1 ? 31'h0000_01ff :
           m == 3'd2 ? 31'h0000_1fff :
           m == 3'd3 ? 31'h0000_7fff :
           m == 3'd4 ? 31'h007f_ffff :
           m == 3'd5 ? 31'h7fff_ffff : 31'h0000_007f;
  endfunction
  function automatic logic [30:0] tap_of(input logic [2:0] m);
    return m == 3'd1 ? 31'h0000_0110 :
           m == 3'd2 ? 31'h0000_1803 :
           m == 3'd3 ? 31'h0000_6000 :
           m == 3'd4 ? 31'h0042_0000 :
           m == 3'd5 ? 31'h4800_0000 : 31'h0000_0060;
  endfunction
  logic [2:0]        mode_q;
  logic [30:0]       state, nxt, tap, len, ld_len, ld_seed;
  logic [DATA_W-1:0] word;
  logic              pend, produce;
  assign tap     = tap_of(mode_q);
  assign len     = len_of(mode_q);
  assign ld_len  = len_of(mode);
  assign ld_seed = seed & ld_len;
  assign produce = en && (!valid || ready);
  always_comb begin
    nxt  = state;
    word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      word[DATA_W-1-i] = ^(nxt & tap);
      nxt = {nxt[29:0], word[DATA_W-1-i]} & len;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= mode;
      state    <= ld_len;
      dout     <= '0;
      valid    <= 1'b0;
      word_cnt <= '0;
      pend     <= 1'b0;
    end else if (load) begin
      mode_q <= mode;
      state  <= |ld_seed ? ld_seed : ld_len;
      valid  <= 1'b0;
      pend   <= 1'b0;
    end else begin
      word_cnt <= word_cnt + CNT_W'(valid && ready);
      pend     <= (pend | inj_err) & !produce;
      if (produce) begin
        dout  <= word ^ DATA_W'(pend | inj_err);
        state <= nxt;
      end
      if (!valid || ready) valid <= en;
    end
  end
endmodule

// File: tb/tb_prbs_gen_par.sv
// tb_prbs_gen_par: directed vector table plus model-checked sequences for prbs_gen_par
module tb_prbs_gen_par;
  logic        clock = 1'b0;
  logic        reset, en, load, inj_err, ready;
  logic [2:0]  mode;
  logic [30:0] seed;
  logic [7:0]  dout;
  logic        valid;
  logic [31:0] word_cnt;
  logic        reset1;
  logic [2:0]  mode1;
  logic [0:0]  dout1;
  logic        valid1;
  logic [31:0] cnt1;
  int checks = 0;
  int errors = 0;
  logic [63:0] mh;
  logic [2:0]  mm;
  logic [7:0]  lw;
  logic        bits [16400];

  always #5 clock = ~clock;

  prbs_gen_par #(.DATA_W(8), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .en(en), .load(load), .mode(mode), .seed(seed),
    .inj_err(inj_err), .dout(dout), .valid(valid), .ready(ready), .word_cnt(word_cnt)
  );
  prbs_gen_par #(.DATA_W(1), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset1), .en(1'b1), .load(1'b0), .mode(mode1), .seed(31'h0),
    .inj_err(1'b0), .dout(dout1), .valid(valid1), .ready(1'b1), .word_cnt(cnt1)
  );

  typedef struct {
    logic       en, rdy, inj, v;
    logic [7:0] d;
    int         c;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int tap_e(input logic [2:0] m, input int k);
    int t [4];
    case (m)
      3'd1: t = '{9, 5, 0, 0};
      3'd2: t = '{13, 12, 2, 1};
      3'd3: t = '{15, 14, 0, 0};
      3'd4: t = '{23, 18, 0, 0};
      3'd5: t = '{31, 28, 0, 0};
      default: t = '{7, 6, 0, 0};
    endcase
    return t[k];
  endfunction

  task automatic model_next(output logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      logic b;
      b = 1'b0;
      for (int k = 0; k < 4; k++)
        if (tap_e(mm, k) != 0) b ^= mh[tap_e(mm, k) - 1];
      w[7-i] = b;
      mh = {mh[62:0], b};
    end
  endtask

  task automatic run_words(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      ready = 1'b1;
      tick;
      model_next(lw);
      chk("stream_dout", dout, lw);
      chk("stream_valid", valid, 1'b1);
    end
  endtask

  task automatic period_check(input logic [2:0] m, input int n, input int p);
    int mism, zwin, ones;
    reset1 = 1'b1;
    mode1 = m;
    tick;
    reset1 = 1'b0;
    mode1 = 3'd0;
    for (int i = 0; i < 2 * p; i++) begin
      tick;
      bits[i] = dout1[0];
    end
    mism = 0;
    zwin = 0;
    ones = 0;
    for (int i = 0; i < p; i++) begin
      int run;
      if (bits[i] !== bits[i+p]) mism++;
      if (bits[i]) ones++;
      run = 0;
      for (int k = 0; k < n; k++) run += int'(bits[i+k]);
      if (run == 0) zwin++;
    end
    chk("period_repeat", 64'(mism), 64'd0);
    chk("period_ones", 64'(ones), 64'((p + 1) / 2));
    chk("period_no_zero_state", 64'(zwin), 64'd0);
    chk("period_valid", valid1, 1'b1);
  endtask

  initial begin
    int nerr;
    logic [7:0] diff;
    logic [7:0] hold;
    reset = 1'b1; en = 1'b1; load = 1'b0; inj_err = 1'b0; ready = 1'b1;
    mode = 3'd0; seed = 31'h0; reset1 = 1'b1; mode1 = 3'd0;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h0c, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h0c, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h0c, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h28, 2};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h28, 3};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h28, 3};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hf3, 3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h2c, 4};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h2c, 4};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'heb, 5};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h7d, 6};
    tick;
    chk("reset_dout", dout, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_cnt", word_cnt, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en;
      ready = tbl[i].rdy;
      inj_err = tbl[i].inj;
      tick;
      inj_err = 1'b0;
      chk($sformatf("vec%0d_dout", i), dout, tbl[i].d);
      chk($sformatf("vec%0d_valid", i), valid, tbl[i].v);
      chk($sformatf("vec%0d_cnt", i), word_cnt, 64'(tbl[i].c));
    end
    // zero seed falls back to all ones; valid drops for the load cycle only
    load = 1'b1; seed = 31'h0; mode = 3'd3;
    tick;
    load = 1'b0;
    chk("zseed_valid", valid, 1'b0);
    chk("zseed_cnt", word_cnt, 32'd6);
    mm = 3'd3;
    mh = 64'h7fff;
    run_words(4);
    chk("zseed_cnt_after", word_cnt, 32'd9);
    hold = lw;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_dout", dout, hold);
      chk("stall_valid", valid, 1'b1);
    end
    chk("stall_cnt", word_cnt, 32'd9);
    run_words(3);
    chk("bp_cnt", word_cnt, 32'd12);
    nerr = 0;
    diff = 8'h00;
    for (int i = 0; i < 6; i++) begin
      en = 1'b1;
      ready = 1'b1;
      inj_err = (i == 1);
      tick;
      inj_err = 1'b0;
      model_next(lw);
      if (dout !== lw) begin
        nerr++;
        diff = dout ^ lw;
      end
    end
    chk("inj_count", 64'(nerr), 64'd1);
    chk("inj_bit", diff, 8'h01);
    chk("inj_cnt", word_cnt, 32'd18);
    ready = 1'b0;
    tick;
    chk("ldstall_valid_pre", valid, 1'b1);
    load = 1'b1; seed = 31'h1234_5655; mode = 3'd1;
    tick;
    load = 1'b0;
    mode = 3'd5;
    chk("ldstall_valid", valid, 1'b0);
    chk("ldstall_cnt", word_cnt, 32'd18);
    mm = 3'd1;
    mh = 64'(seed);
    run_words(3);
    chk("ldstall_cnt_after", word_cnt, 32'd20);
    reset = 1'b1; load = 1'b1; inj_err = 1'b1; mode = 3'd5; seed = 31'h3;
    tick;
    reset = 1'b0; load = 1'b0; inj_err = 1'b0; mode = 3'd0;
    chk("simul_dout", dout, 8'h00);
    chk("simul_valid", valid, 1'b0);
    chk("simul_cnt", word_cnt, 32'd0);
    mm = 3'd5;
    mh = 64'h7fff_ffff;
    run_words(5);
    chk("simul_cnt_after", word_cnt, 32'd4);
    period_check(3'd0, 7, 127);
    period_check(3'd2, 13, 8191);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
